shift_add_mult_datapath: RTL and testbench

Datapath of a sequential shift-and-add unsigned multiplier. It holds three registers:
- A: multiplicand, shifted left each step.
- B: multiplier, shifted right each step.
- P: product accumulator.

An external controller FSM drives the load/shift/add selects and enables. It reads back the status flags `zero` and `lsb_b`. The internal register values and next-value buses are exported for debug.

---
 rtl/shift_add_mult_datapath.sv | 68 ++++++
 tb/tb_shift_add_mult_datapath.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_datapath.sv
// Datapath for a sequential shift-and-add unsigned multiplier: A shifts left, B shifts right,
// P accumulates A whenever the controller sees B[0] set. Sequencing lives in an external controller.
module shift_add_mult_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  input  logic           en_a,
  input  logic           ld_shift_a,
  input  logic           en_b,
  input  logic           ld_shift_b,
  input  logic           en_p,
  input  logic           ld_add_p,
  output logic [2*N-1:0] p_out,
  output logic           zero,
  output logic           lsb_b,
  output logic [2*N-1:0] p,
  output logic [2*N-1:0] a,
  output logic [2*N-1:0] a_shift,
  output logic [2*N-1:0] p_add,
  output logic [N-1:0]   b,
  output logic [N-1:0]   b_shift
);

  logic [2*N-1:0] a_reg;
  logic [N-1:0]   b_reg;
  logic [2*N-1:0] p_reg;

  // Next-value buses are built only from pre-edge register contents, so all
  // three registers can update together in one step cycle.
  assign a_shift = {a_reg[2*N-2:0], 1'b0};
  assign b_shift = {1'b0, b_reg[N-1:1]};
  assign p_add   = p_reg + a_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_reg <= '0;
    end else if (en_a) begin
      a_reg <= ld_shift_a ? a_shift : {{N{1'b0}}, a_in};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      b_reg <= '0;
    end else if (en_b) begin
      b_reg <= ld_shift_b ? b_shift : b_in;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      p_reg <= '0;
    end else if (en_p) begin
      p_reg <= ld_add_p ? p_add : '0;
    end
  end

  assign zero  = (b_reg == '0);
  assign lsb_b = b_reg[0];
  assign p_out = p_reg;
  assign p     = p_reg;
  assign a     = a_reg;
  assign b     = b_reg;

endmodule

// File: tb/tb_shift_add_mult_datapath.sv
// Directed bench for the shift-and-add multiplier datapath, acting as its controller;
// products are queued at load time and compared when zero rises.
module tb_shift_add_mult_datapath;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic [N-1:0]   a_in, b_in;
  logic           en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p;
  logic [2*N-1:0] p_out, p, a, a_shift, p_add;
  logic           zero, lsb_b;
  logic [N-1:0]   b, b_shift;

  logic [2*N-1:0] sb[$];
  int             total = 0;
  int             pass_cnt = 0;

  shift_add_mult_datapath #(.N(N)) dut (
    .clk(clk), .clr(clr), .a_in(a_in), .b_in(b_in),
    .en_a(en_a), .ld_shift_a(ld_shift_a), .en_b(en_b), .ld_shift_b(ld_shift_b),
    .en_p(en_p), .ld_add_p(ld_add_p), .p_out(p_out), .zero(zero), .lsb_b(lsb_b),
    .p(p), .a(a), .a_shift(a_shift), .p_add(p_add), .b(b), .b_shift(b_shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; en_p = 1'b0;
  endtask

  task automatic drive_load(input logic [N-1:0] x, input logic [N-1:0] y);
    a_in = x; b_in = y;
    en_a = 1'b1; en_b = 1'b1; en_p = 1'b1;
    ld_shift_a = 1'b0; ld_shift_b = 1'b0; ld_add_p = 1'b0;
  endtask

  task automatic drive_step();
    en_a = 1'b1; en_b = 1'b1; en_p = lsb_b;
    ld_shift_a = 1'b1; ld_shift_b = 1'b1; ld_add_p = 1'b1;
  endtask

  task automatic run_mult(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] ex, ey, exp_v;
    int steps;
    ex = {{N{1'b0}}, x};
    ey = {{N{1'b0}}, y};
    drive_load(x, y);
    tick();
    sb.push_back(ex * ey);
    chk("load_p", 16'(p), 16'h0);
    chk("load_a", 16'(a), 16'(ex));
    chk("load_b", 16'(b), 16'(y));
    steps = 0;
    while (zero !== 1'b1 && steps <= N) begin
      drive_step();
      tick();
      steps++;
    end
    idle();
    chk("step_bound", 16'(steps <= N), 16'h1);
    chk("done_zero", 16'(zero), 16'h1);
    exp_v = sb.pop_front();
    chk("product", 16'(p_out), 16'(exp_v));
  endtask

  initial begin
    // Reset with random inputs and enables active
    clr = 1'b0;
    a_in = N'($urandom); b_in = N'($urandom);
    en_a = 1'b1; en_b = 1'b1; en_p = 1'b1;
    ld_shift_a = 1'($urandom); ld_shift_b = 1'($urandom); ld_add_p = 1'($urandom);
    tick();
    tick();
    chk("rst_a", 16'(a), 16'h0);
    chk("rst_b", 16'(b), 16'h0);
    chk("rst_p", 16'(p_out), 16'h0);
    chk("rst_zero", 16'(zero), 16'h1);
    chk("rst_lsb", 16'(lsb_b), 16'h0);
    idle();
    #2 clr = 1'b1;
    tick();
    tick();
    chk("post_rst_a", 16'(a), 16'h0);
    chk("post_rst_b", 16'(b), 16'h0);
    chk("post_rst_p", 16'(p), 16'h0);

    // Load 2 x 3 and inspect every debug bus
    drive_load(4'd2, 4'd3);
    tick();
    sb.push_back(8'd6);
    chk("ld_a", 16'(a), 16'h02);
    chk("ld_b", 16'(b), 16'h3);
    chk("ld_p", 16'(p), 16'h0);
    chk("ld_lsb", 16'(lsb_b), 16'h1);
    chk("ld_zero", 16'(zero), 16'h0);
    chk("ld_ashift", 16'(a_shift), 16'h04);
    chk("ld_bshift", 16'(b_shift), 16'h1);
    chk("ld_padd", 16'(p_add), 16'h02);

    drive_step();
    tick();
    chk("s1_p", 16'(p), 16'h2);
    chk("s1_a", 16'(a), 16'h4);
    chk("s1_b", 16'(b), 16'h1);
    drive_step();
    tick();
    chk("s2_p", 16'(p), 16'h6);
    chk("s2_a", 16'(a), 16'h8);
    chk("s2_b", 16'(b), 16'h0);
    chk("s2_zero", 16'(zero), 16'h1);
    chk("s2_pout", 16'(p_out), 16'(sb.pop_front()));

    // Hold: enables low while inputs and selects toggle
    idle();
    for (int i = 0; i < 3; i++) begin
      a_in = N'($urandom); b_in = N'($urandom);
      ld_shift_a = ~ld_shift_a; ld_shift_b = ~ld_shift_b; ld_add_p = ~ld_add_p;
      tick();
    end
    chk("hold_a", 16'(a), 16'h8);
    chk("hold_b", 16'(b), 16'h0);
    chk("hold_p", 16'(p), 16'h6);

    // Extremes and scoreboarded random products
    run_mult(4'hF, 4'hF);
    chk("ff_pout", 16'(p_out), 16'hE1);
    drive_load(4'h9, 4'h0);
    tick();
    idle();
    chk("x0_zero", 16'(zero), 16'h1);
    chk("x0_pout", 16'(p_out), 16'h0);
    run_mult(4'h0, 4'h9);
    for (int i = 0; i < 6; i++) run_mult(N'($urandom), N'($urandom));

    // A shifted left until every bit has fallen off the top
    drive_load(4'hF, 4'h0);
    tick();
    en_a = 1'b1; ld_shift_a = 1'b1; en_b = 1'b0; en_p = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("sh4_a", 16'(a), 16'hF0);
    tick();
    chk("sh5_a", 16'(a), 16'hE0);
    for (int i = 0; i < 3; i++) tick();
    chk("sh8_a", 16'(a), 16'h00);
    idle();

    // Asynchronous reset between edges, mid-multiply
    drive_load(4'hD, 4'hB);
    tick();
    drive_step();
    tick();
    chk("mid_p", 16'(p), 16'h0D);
    #3 clr = 1'b0;
    #1;
    chk("async_a", 16'(a), 16'h0);
    chk("async_b", 16'(b), 16'h0);
    chk("async_p", 16'(p), 16'h0);
    chk("async_zero", 16'(zero), 16'h1);
    idle();
    #1 clr = 1'b1;
    tick();
    chk("after_async_p", 16'(p_out), 16'h0);
    run_mult(4'hD, 4'hB);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
